// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   fetch_state_t : FSM state encoding (2 bits)
//   XLEN          : datapath / address width
//   NOP_INST      : canonical NOP encoding (addi x0, x0, 0)
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter used as the fetch memory-timeout timer.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (count -> 0)
//   i_inc  : count one cycle
//   i_clr  : clear count (wins over i_inc)
//   o_max  : count has reached MAX (stays there until cleared)
module sat_counter #(
    parameter int          WIDTH = 16,
    parameter int unsigned MAX   = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_max
);

    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != L_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_max = (r_count == L_MAX);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the PC register's enable / next-PC,
// keeps a single request outstanding to a variable-latency instruction
// memory, and hands fetched words to IF/ID with a valid/stall handshake.
// Redirects (branch/jump/flush) win over every other event.
//
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_pc, i_inc_pc         : current PC and PC+4 from the PC register
//   i_redirect(_pc)        : redirect request and its target
//   i_stall                : decode cannot take the held instruction
//   o_if_en, o_next_pc     : PC register update enable and value
//   o_imem_req/_addr       : memory request and address
//   i_imem_gnt             : request accepted
//   i_imem_rvalid/_rdata   : memory response
//   o_inst_valid/_inst/_pc : instruction presented to IF/ID
//   o_timeout              : sticky memory-timeout flag
//
// state  | meaning
// S_BOOT | first cycle after reset, nothing issued
// S_REQ  | presenting request for i_pc, waiting for grant
// S_WAIT | request granted, waiting for response (drop = discard it)
// S_HOLD | instruction valid to decode, waiting to be consumed
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYCLES = 255,
    parameter logic [XLEN-1:0] RESET_VECTOR   = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inc_pc,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_stall,
    output logic            o_if_en,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    output logic            o_timeout
);

    fetch_state_t    r_state;
    logic            r_drop;
    logic            r_inst_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_timeout;

    logic w_in_req;
    logic w_in_wait;
    logic w_in_hold;
    logic w_deliver;
    logic w_cnt_max;

    assign w_in_req  = (r_state == S_REQ);
    assign w_in_wait = (r_state == S_WAIT);
    assign w_in_hold = (r_state == S_HOLD);

    // Response accepted into IF/ID; this is also the only way into S_HOLD.
    assign w_deliver = w_in_wait & i_imem_rvalid & ~r_drop & ~i_redirect;

    assign o_next_pc   = i_redirect ? i_redirect_pc : i_inc_pc;
    assign o_if_en     = i_redirect | (w_in_hold & ~i_stall);
    // Request is withdrawn during a redirect so no grant can land on a stale PC.
    assign o_imem_req  = w_in_req & ~i_redirect;
    assign o_imem_addr = w_in_req ? i_pc : '0;

    assign o_inst_valid = r_inst_valid;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_timeout    = r_timeout;

    // Entry into S_BOOT only happens through reset, which also clears the counter.
    sat_counter #(
        .WIDTH (16),
        .MAX   (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_in_req | w_in_wait),
        .i_clr (w_deliver),
        .o_max (w_cnt_max)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_BOOT;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_cnt_max) begin
                r_timeout <= 1'b1;
            end

            case (r_state)
                S_BOOT: begin
                    r_state <= S_REQ;
                end

                S_REQ: begin
                    if (!i_redirect && i_imem_gnt) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (w_deliver) begin
                            r_inst       <= i_imem_rdata;
                            r_inst_pc    <= i_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end else begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end else if (i_redirect) begin
                        // The in-flight response belongs to the old stream.
                        r_drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (i_redirect || !i_stall) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    // Once a response has been delivered nothing is outstanding, so a
    // response seen in S_HOLD has no matching grant.
    always @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_in_hold) begin
                assert (!i_imem_rvalid)
                    else $error("fetch_ctrl: rvalid with no outstanding grant");
            end
            if (r_state == S_BOOT) begin
                assert (i_pc == RESET_VECTOR)
                    else $error("fetch_ctrl: PC not at reset vector after reset");
            end
        end
    end

endmodule
